in_buf_sequencer: RTL and testbench

IN_BUF_SEQUENCER -- requirements
Module: in_buf_sequencer

---
 rtl/in_buf_sequencer_pkg.sv | 23 ++
 rtl/in_buf_sequencer_if.sv | 27 ++
 rtl/in_buf_sequencer_pps_collector.sv | 61 ++++++
 rtl/in_buf_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_in_buf_sequencer.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/in_buf_sequencer_pkg.sv
// Shared definitions for the input-buffer sequencer: FSM state encoding,
// sticky error codes and a small sizing helper.
package in_buf_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PPS  = 2'd1,
        ST_DATA = 2'd2
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_PPS_BROKEN = 2'd1,
        ERR_EARLY_SOF  = 2'd2,
        ERR_EARLY_PPS  = 2'd3
    } seq_err_e;

    // Width of an index able to address 'words' entries, never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/in_buf_sequencer_if.sv
// Input-buffer read side plus the PPS/slice output stream of the sequencer.
interface in_buf_sequencer_if #(
    parameter int DATA_WIDTH = 256,
    parameter int PPS_WORDS  = 4
);
    logic [DATA_WIDTH-1:0]           in_data;
    logic                            in_valid;
    logic                            in_sof;
    logic                            in_data_is_pps;
    logic                            flush;
    logic [PPS_WORDS*DATA_WIDTH-1:0] pps_data;
    logic                            pps_valid;
    logic [DATA_WIDTH-1:0]           slice_data;
    logic                            slice_valid;
    logic                            slice_sof;
    logic                            frame_done;

    modport master (
        output in_data, in_valid, in_sof, in_data_is_pps,
        input  flush, pps_data, pps_valid, slice_data, slice_valid, slice_sof, frame_done
    );

    modport slave (
        input  in_data, in_valid, in_sof, in_data_is_pps,
        output flush, pps_data, pps_valid, slice_data, slice_valid, slice_sof, frame_done
    );
endinterface

// File: rtl/in_buf_sequencer_pps_collector.sv
// Assembles PPS words by index; publishes the full PPS (word 0 in LSBs) and a
// one-cycle full pulse when the last index is written.
module pps_collector
    import in_buf_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int PPS_WORDS  = 4,
    parameter int IDX_W      = idx_width(PPS_WORDS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [DATA_WIDTH-1:0]           word_in,
    output logic [PPS_WORDS*DATA_WIDTH-1:0] pps_data,
    output logic                            full
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PPS_WORDS - 1);

    logic [DATA_WIDTH-1:0]           asm_r [PPS_WORDS];
    logic [PPS_WORDS*DATA_WIDTH-1:0] pps_next_s;
    logic [PPS_WORDS*DATA_WIDTH-1:0] pps_data_r;
    logic                            full_s;
    logic                            full_r;

    assign full_s = wr_en && (wr_idx == LAST_IDX);

    // Image of the completed PPS including the word being written this cycle.
    always_comb begin
        pps_next_s = {(PPS_WORDS*DATA_WIDTH){1'b0}};
        for (int i = 0; i < PPS_WORDS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                pps_next_s[i*DATA_WIDTH +: DATA_WIDTH] = word_in;
            end else begin
                pps_next_s[i*DATA_WIDTH +: DATA_WIDTH] = asm_r[i];
            end
        end
    end

    // Assembly store and published PPS; the published copy only moves on completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PPS_WORDS; i++) begin
                asm_r[i] <= {DATA_WIDTH{1'b0}};
            end
            pps_data_r <= {(PPS_WORDS*DATA_WIDTH){1'b0}};
            full_r     <= 1'b0;
        end else begin
            if (wr_en) begin
                asm_r[wr_idx] <= word_in;
            end
            if (full_s) begin
                pps_data_r <= pps_next_s;
            end
            full_r <= full_s;
        end
    end

    assign pps_data = pps_data_r;
    assign full     = full_r;
endmodule

// File: rtl/in_buf_sequencer.sv
// Splits the input buffer stream into a PPS header and the slice words of one
// frame, flagging protocol violations with a sticky error code and a flush.
module in_buf_sequencer
    import in_buf_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int PPS_WORDS  = 4,
    parameter int CNT_WIDTH  = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CNT_WIDTH-1:0] frame_words,
    input  logic                 sw_flush,
    input  logic                 err_clr,
    output logic [1:0]           err,
    output logic                 busy,
    in_buf_sequencer_if.slave    bus
);
    localparam int                   IDX_W    = idx_width(PPS_WORDS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(PPS_WORDS - 1);
    localparam logic [IDX_W-1:0]     IDX_ZERO = IDX_W'(0);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    seq_state_e            state_r, state_nx;
    seq_err_e              err_r, err_nx, code_s;
    logic [IDX_W-1:0]      idx_r, idx_nx, wr_idx_s;
    logic [CNT_WIDTH-1:0]  cnt_r, cnt_nx;
    logic                  first_r, first_nx;
    logic                  word_s, pps_store_s, wr_en_s;
    logic                  slice_we_s, slice_sof_s, done_s, flush_s;
    logic                  flush_r, slice_valid_r, slice_sof_r, frame_done_r, busy_r;
    logic [DATA_WIDTH-1:0] slice_data_r;
    logic [PPS_WORDS*DATA_WIDTH-1:0] pps_data_s;
    logic                  pps_full_s;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next state, word routing and error detection; words arriving while flush is high are ignored.
    always_comb begin
        state_nx    = state_r;
        idx_nx      = idx_r;
        cnt_nx      = cnt_r;
        first_nx    = first_r;
        wr_idx_s    = idx_r;
        wr_en_s     = 1'b0;
        pps_store_s = 1'b0;
        slice_we_s  = 1'b0;
        slice_sof_s = 1'b0;
        done_s      = 1'b0;
        flush_s     = 1'b0;
        code_s      = ERR_NONE;
        err_nx      = err_r;
        word_s      = bus.in_valid & ~flush_r;

        if (sw_flush) begin
            flush_s = 1'b1;
        end else if (word_s) begin
            case (state_r)
                ST_IDLE: begin
                    wr_idx_s    = IDX_ZERO;
                    pps_store_s = bus.in_sof & bus.in_data_is_pps;
                end
                ST_PPS: begin
                    if (bus.in_data_is_pps) begin
                        pps_store_s = 1'b1;
                    end else begin
                        code_s = ERR_PPS_BROKEN;
                    end
                end
                ST_DATA: begin
                    if (bus.in_sof) begin
                        code_s = ERR_EARLY_SOF;
                    end else if (bus.in_data_is_pps) begin
                        code_s = ERR_EARLY_PPS;
                    end else begin
                        slice_we_s  = 1'b1;
                        slice_sof_s = first_r;
                        first_nx    = 1'b0;
                        if (cnt_r == CNT_ONE) begin
                            done_s   = 1'b1;
                            state_nx = ST_IDLE;
                            cnt_nx   = CNT_ZERO;
                        end else begin
                            cnt_nx = cnt_r - CNT_ONE;
                        end
                    end
                end
                default: begin
                    flush_s = 1'b1;
                end
            endcase
        end else begin
            state_nx = state_r;
        end

        // A completed PPS samples the frame length; an empty frame ends immediately.
        if (pps_store_s) begin
            wr_en_s = 1'b1;
            if (wr_idx_s == LAST_IDX) begin
                idx_nx   = IDX_ZERO;
                cnt_nx   = frame_words;
                first_nx = 1'b1;
                if (frame_words == CNT_ZERO) begin
                    done_s   = 1'b1;
                    state_nx = ST_IDLE;
                end else begin
                    state_nx = ST_DATA;
                end
            end else begin
                idx_nx   = wr_idx_s + IDX_ONE;
                state_nx = ST_PPS;
            end
        end else begin
            wr_en_s = 1'b0;
        end

        if (flush_s || (code_s != ERR_NONE)) begin
            flush_s  = 1'b1;
            state_nx = ST_IDLE;
            idx_nx   = IDX_ZERO;
            cnt_nx   = CNT_ZERO;
            first_nx = 1'b0;
        end else begin
            flush_s = 1'b0;
        end

        if (err_clr) begin
            err_nx = code_s;
        end else if (err_r != ERR_NONE) begin
            err_nx = err_r;
        end else begin
            err_nx = code_s;
        end
    end

    // Counters, sticky error and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r         <= IDX_ZERO;
            cnt_r         <= CNT_ZERO;
            first_r       <= 1'b0;
            err_r         <= ERR_NONE;
            flush_r       <= 1'b0;
            slice_valid_r <= 1'b0;
            slice_sof_r   <= 1'b0;
            frame_done_r  <= 1'b0;
            busy_r        <= 1'b0;
            slice_data_r  <= {DATA_WIDTH{1'b0}};
        end else begin
            idx_r         <= idx_nx;
            cnt_r         <= cnt_nx;
            first_r       <= first_nx;
            err_r         <= err_nx;
            flush_r       <= flush_s;
            slice_valid_r <= slice_we_s;
            slice_sof_r   <= slice_sof_s;
            frame_done_r  <= done_s;
            busy_r        <= (state_nx != ST_IDLE);
            if (slice_we_s) begin
                slice_data_r <= bus.in_data;
            end
        end
    end

    pps_collector #(
        .DATA_WIDTH (DATA_WIDTH),
        .PPS_WORDS  (PPS_WORDS),
        .IDX_W      (IDX_W)
    ) u_pps_collector (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en_s),
        .wr_idx   (wr_idx_s),
        .word_in  (bus.in_data),
        .pps_data (pps_data_s),
        .full     (pps_full_s)
    );

    assign bus.flush       = flush_r;
    assign bus.pps_data    = pps_data_s;
    assign bus.pps_valid   = pps_full_s;
    assign bus.slice_data  = slice_data_r;
    assign bus.slice_valid = slice_valid_r;
    assign bus.slice_sof   = slice_sof_r;
    assign bus.frame_done  = frame_done_r;
    assign err             = err_r;
    assign busy            = busy_r;
endmodule

// File: tb/tb_in_buf_sequencer.sv
// Self-checking bench: directed protocol scenarios plus randomized frames,
// every output compared each cycle against a queue-based reference model.
module tb_in_buf_sequencer;
    localparam int DW = 256;
    localparam int PW = 4;
    localparam int CW = 24;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CW-1:0] frame_words;
    logic          sw_flush;
    logic          err_clr;
    logic [1:0]    err;
    logic          busy;

    in_buf_sequencer_if #(.DATA_WIDTH(DW), .PPS_WORDS(PW)) bus ();

    in_buf_sequencer #(.DATA_WIDTH(DW), .PPS_WORDS(PW), .CNT_WIDTH(CW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_words (frame_words),
        .sw_flush    (sw_flush),
        .err_clr     (err_clr),
        .err         (err),
        .busy        (busy),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: collected PPS words in a queue, remaining slice words as an integer.
    logic [DW-1:0] pq[$];
    bit            in_frame;
    int            left;
    bit            first;
    bit            e_flush, e_pv, e_sv, e_sof, e_fd, e_busy;
    logic [1:0]    e_err;
    logic [DW-1:0] e_sd;
    logic [DW-1:0] e_pps [PW];
    int            n_pv, n_sv, n_fd, n_sof;
    logic [DW-1:0] last_pps [PW];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_word();
        logic [DW-1:0] w;
        for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic model_reset();
        pq.delete();
        in_frame = 1'b0; left = 0; first = 1'b0;
        e_flush = 1'b0; e_pv = 1'b0; e_sv = 1'b0; e_sof = 1'b0; e_fd = 1'b0; e_busy = 1'b0;
        e_err = 2'd0; e_sd = '0;
        for (int i = 0; i < PW; i++) e_pps[i] = '0;
    endtask

    task automatic model_step(input bit v, input bit s, input bit p, input logic [DW-1:0] d,
                              input bit swf, input bit clr);
        bit ign;
        int code;
        ign = e_flush;
        code = 0;
        e_flush = 1'b0; e_pv = 1'b0; e_sv = 1'b0; e_sof = 1'b0; e_fd = 1'b0;
        if (swf) begin
            pq.delete(); in_frame = 1'b0; e_flush = 1'b1;
        end else if (v && !ign) begin
            if (in_frame) begin
                if (s) code = 2;
                else if (p) code = 3;
                else begin
                    e_sv = 1'b1; e_sd = d; e_sof = first; first = 1'b0;
                    left--;
                    if (left == 0) begin e_fd = 1'b1; in_frame = 1'b0; end
                end
            end else if (pq.size() != 0) begin
                if (p) pq.push_back(d);
                else code = 1;
            end else if (s && p) begin
                pq.push_back(d);
            end
            if (pq.size() == PW) begin
                for (int i = 0; i < PW; i++) e_pps[i] = pq[i];
                pq.delete();
                e_pv = 1'b1;
                left = int'(frame_words);
                if (left == 0) e_fd = 1'b1;
                else begin in_frame = 1'b1; first = 1'b1; end
            end
        end
        if (code != 0) begin e_flush = 1'b1; pq.delete(); in_frame = 1'b0; end
        if (clr || e_err == 2'd0) e_err = 2'(code);
        e_busy = in_frame || (pq.size() != 0);
    endtask

    task automatic compare_all();
        check_val("flush",       DW'(bus.flush),       DW'(e_flush));
        check_val("pps_valid",   DW'(bus.pps_valid),   DW'(e_pv));
        check_val("slice_valid", DW'(bus.slice_valid), DW'(e_sv));
        check_val("slice_sof",   DW'(bus.slice_sof),   DW'(e_sof));
        check_val("frame_done",  DW'(bus.frame_done),  DW'(e_fd));
        check_val("err",         DW'(err),             DW'(e_err));
        check_val("busy",        DW'(busy),            DW'(e_busy));
        check_val("slice_data",  bus.slice_data,       e_sd);
        for (int i = 0; i < PW; i++)
            check_val($sformatf("pps_data[%0d]", i), bus.pps_data[i*DW +: DW], e_pps[i]);
    endtask

    task automatic step(input bit v, input bit s, input bit p, input logic [DW-1:0] d,
                        input bit swf, input bit clr);
        bus.in_valid = v; bus.in_sof = s; bus.in_data_is_pps = p; bus.in_data = d;
        sw_flush = swf; err_clr = clr;
        model_step(v, s, p, d, swf, clr);
        @(posedge clk);
        @(negedge clk);
        compare_all();
        if (bus.pps_valid)   n_pv++;
        if (bus.slice_valid) n_sv++;
        if (bus.frame_done)  n_fd++;
        if (bus.slice_sof)   n_sof++;
    endtask

    task automatic idle();
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_word(), 1'b0, 1'b0);
    endtask

    task automatic clr_counts();
        n_pv = 0; n_sv = 0; n_fd = 0; n_sof = 0;
    endtask

    task automatic send_pps(input int nwords);
        for (int i = 0; i < nwords; i++) begin
            last_pps[i] = rnd_word();
            step(1'b1, i == 0, 1'b1, last_pps[i], 1'b0, 1'b0);
        end
    endtask

    task automatic send_slices(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, rnd_word(), 1'b0, 1'b0);
    endtask

    // Random word with occasional gaps, soft flushes and error clears.
    task automatic rword(input bit s, input bit p);
        repeat ($urandom_range(0, 1)) idle();
        step(1'b1, s, p, rnd_word(), $urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0);
    endtask

    initial begin
        rst_n = 1'b0; sw_flush = 1'b0; err_clr = 1'b0; frame_words = 24'd3;
        bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_data_is_pps = 1'b0; bus.in_data = '0;
        model_reset();
        clr_counts();
        repeat (2) @(negedge clk);
        compare_all();
        rst_n = 1'b1;
        idle();

        // Clean frame of three slice words.
        clr_counts();
        send_pps(PW); send_slices(3); idle();
        check_val("f1_pps_cnt",   DW'(n_pv),  DW'(1));
        check_val("f1_slice_cnt", DW'(n_sv),  DW'(3));
        check_val("f1_sof_cnt",   DW'(n_sof), DW'(1));
        check_val("f1_done_cnt",  DW'(n_fd),  DW'(1));
        check_val("f1_err",       DW'(err),   DW'(0));

        // Broken PPS.
        clr_counts();
        send_pps(2);
        step(1'b1, 1'b0, 1'b0, rnd_word(), 1'b0, 1'b0);
        check_val("f2_flush", DW'(bus.flush), DW'(1));
        idle();
        check_val("f2_err",     DW'(err),  DW'(1));
        check_val("f2_pps_cnt", DW'(n_pv), DW'(0));
        check_val("f2_busy",    DW'(busy), DW'(0));
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Early SOF in the slice stream, then a clean frame keeps the sticky code.
        clr_counts();
        send_pps(PW); send_slices(1);
        step(1'b1, 1'b1, 1'b0, rnd_word(), 1'b0, 1'b0);
        idle();
        send_pps(PW); send_slices(3); idle();
        check_val("f3_slice_cnt", DW'(n_sv), DW'(4));
        check_val("f3_err",       DW'(err),  DW'(2));
        step(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_val("f3_err_clr",   DW'(err),  DW'(0));

        // Empty frame.
        clr_counts();
        frame_words = 24'd0;
        send_pps(PW);
        check_val("f4_pps_valid",  DW'(bus.pps_valid),  DW'(1));
        check_val("f4_frame_done", DW'(bus.frame_done), DW'(1));
        idle();
        check_val("f4_slice_cnt",  DW'(n_sv), DW'(0));

        // Soft flush mid-PPS, then a full frame.
        clr_counts();
        frame_words = 24'd3;
        send_pps(2);
        step(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        idle();
        send_pps(PW); send_slices(3); idle();
        for (int i = 0; i < PW; i++)
            check_val($sformatf("f5_pps[%0d]", i), bus.pps_data[i*DW +: DW], last_pps[i]);
        check_val("f5_pps_cnt", DW'(n_pv), DW'(1));
        check_val("f5_err",     DW'(err),  DW'(0));

        // Reset in the middle of the slice stream.
        send_pps(PW); send_slices(1);
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        clr_counts();
        send_slices(2); idle(); idle();
        check_val("f6_done_cnt", DW'(n_fd), DW'(0));

        // Randomized frames with occasional protocol violations.
        for (int f = 0; f < 300; f++) begin
            frame_words = CW'($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) rword(1'b0, 1'($urandom_range(0, 1)));
            for (int i = 0; i < PW; i++) begin
                if ($urandom_range(0, 19) == 0) rword(i == 0, 1'b0);
                else rword(i == 0, 1'b1);
            end
            for (int j = 0; j < int'(frame_words); j++) begin
                if ($urandom_range(0, 19) == 0) rword(1'($urandom_range(0, 1)), 1'b1);
                else if ($urandom_range(0, 19) == 0) rword(1'b1, 1'b0);
                else rword(1'b0, 1'b0);
            end
        end
        idle(); idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
